imem_resp: RTL and testbench
============================

# imem_resp

Instruction-memory responder for the fetch stage: the receiving end of the PC's fetch address. It accepts one fetch address per grant, models a configurable number of memory wait states, returns the instruction word with a one-cycle valid pulse, and drives the PC register's enable so the PC advances only when a fetch is accepted. A side write port loads program contents; a flush input discards an in-flight fetch on redirect.

## Interface
- DEPTH_WORDS, 1024: number of 32-bit words; power of two, at least 4.
- WAIT_CYCLES, 1: extra cycles between grant and response; legal range 0..7.
- i_clk  in  1  clock, rising edge.
- in_rst  in  1  reset, asynchronous, active-low.
- i_req  in  1  fetch request; i_addr is valid while high.
- i_addr  in  32  byte address of the fetch; normally the current PC.
- i_flush  in  1  redirect; kills any in-flight fetch and blocks grant this cycle.
- o_gnt  out  1  request accepted this cycle.
- o_pc_enable  out  1  PC advance enable; identical to o_gnt.
- o_rvalid  out  1  one-cycle response strobe.
- o_rdata  out  32  instruction word; meaningful only while o_rvalid is high.
- o_err  out  1  response is a fault (misaligned or out of range); qualified by o_rvalid.
- i_wr_en  in  1  loader write strobe.
- i_wr_addr  in  32  loader byte address; bits [1:0] ignored.
- i_wr_data  in  32  loader write data.

## Operation
- Three states: IDLE, WAIT, RESP. Exactly one fetch is outstanding at a time.
- o_gnt = i_req & !i_flush & (state == IDLE | state == RESP). The grant is combinational from registered state.
- On grant:
  - i_addr is captured.
  - The wait counter loads WAIT_CYCLES-1.
  - Next state is WAIT if WAIT_CYCLES > 0; otherwise it is RESP.
- WAIT:
  - The counter decrements each cycle.
  - When the counter reaches 0, the next state is RESP.
- Entering RESP:
  - The array is read at the captured word index (addr[31:2]).
  - o_rdata and o_err are registered on that same edge.
- RESP:
  - o_rvalid = !i_flush.
  - If a new grant occurs in this cycle, the block follows the grant rule above; otherwise it returns to IDLE.
- Fault: the fetch faults if captured addr[1:0] != 0 or addr[31:2] >= DEPTH_WORDS.
  - o_err = 1.
  - o_rdata = 32'h0000_0013 (NOP). No array read is used.
- Flush:
  - In WAIT, the fetch is discarded and the next state is IDLE. No rvalid is ever produced for it.
  - In RESP, o_rvalid is forced to 0 that cycle and the next state is IDLE.
  - A flush with i_req in the same cycle produces no grant.
- Loader write: synchronous, on any cycle, word index = i_wr_addr[31:2].
  - Out-of-range writes are dropped.
  - If a write and the RESP-entry read hit the same word on the same edge, the read returns the old data.
- Reset values:
  - state IDLE, counter 0, o_rdata 0, o_err 0.
  - o_rvalid 0, and o_gnt/o_pc_enable 0 while in_rst is low.
  - Array contents are not reset.
- Reset mid-fetch: the outstanding fetch is abandoned. No response is issued after reset release.

## Timing
- Grant in cycle N: o_rvalid is high in cycle N+1+WAIT_CYCLES.
- Throughput:
  - WAIT_CYCLES=0 gives one fetch per cycle (grant in RESP overlaps the response).
  - Otherwise one fetch per WAIT_CYCLES+1 cycles.
- o_pc_enable is low in every WAIT cycle and in any cycle with i_flush, so the PC holds the outstanding address.
- o_rdata and o_err hold their values from RESP entry until the next RESP entry.

## Structure
- Package imem_pkg holds:
  - the state enum (IDLE, WAIT, RESP);
  - the NOP constant 32'h0000_0013;
  - the WAIT_CYCLES maximum (7).
- Sub-module imem_array: a single-port-write, single-port-read synchronous RAM of DEPTH_WORDS x 32 with read-before-write. The FSM, counter, fault check and flush logic stay in imem_resp.

## Test plan
- WAIT_CYCLES=1, word 0 preloaded 0x00500093, i_req high with i_addr 0 in cycle 5:
  - o_gnt and o_pc_enable high in cycle 5;
  - o_rvalid high in cycle 7 with o_rdata 0x00500093 and o_err 0;
  - o_gnt low in cycle 6.
- WAIT_CYCLES=0, continuous i_req with addresses 0, 4, 8, 12:
  - o_gnt high every cycle;
  - o_rvalid high every cycle from the second cycle onward, returning the four words in order.
- Misaligned i_addr 0x2 -> o_rvalid with o_err 1 and o_rdata 0x00000013. Address 4*DEPTH_WORDS -> the same fault response.
- WAIT_CYCLES=3, grant at cycle N, i_flush in cycle N+2:
  - no o_rvalid in cycles N+1..N+6;
  - the next request in cycle N+3 is granted.
- Write 0xDEADBEEF to word 8 on the same edge that RESP reads word 8 (old value 0x11111111):
  - the response returns 0x11111111;
  - a refetch of word 8 returns 0xDEADBEEF.
- Assert in_rst low during WAIT:
  - all outputs go to 0 immediately;
  - after release, no stale o_rvalid appears;
  - a new request is granted in the first cycle it is presented.

Source files
------------

// File: rtl/imem_resp_pkg.sv
// imem_pkg: shared types and constants for the instruction-memory responder.
//   state_e      : responder FSM states (IDLE, WAIT, RESP)
//   NOP          : instruction word returned on a faulting fetch
//   WAIT_MAX     : largest supported WAIT_CYCLES value
//   addr_fault() : misaligned / out-of-range fetch check
package imem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam int          WAIT_MAX = 7;

    // A fetch faults when it is not word aligned or its word index lies
    // beyond the array.
    function automatic logic addr_fault(input logic [31:0] addr, input logic [31:0] depth);
        return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth);
    endfunction

endpackage

// File: rtl/imem_resp_if.sv
// imem_resp_if: fetch bus plus loader write port of the instruction memory.
//   i_req/i_addr/i_flush  : fetch request, byte address, redirect
//   o_gnt/o_pc_enable     : request accepted / PC advance enable
//   o_rvalid/o_rdata/o_err: response strobe, instruction word, fault flag
//   i_wr_en/i_wr_addr/i_wr_data : loader write port
// slave  : the responder side; master : the fetch stage / loader side.
interface imem_resp_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_flush;
    logic        o_gnt;
    logic        o_pc_enable;
    logic        o_rvalid;
    logic [31:0] o_rdata;
    logic        o_err;
    logic        i_wr_en;
    logic [31:0] i_wr_addr;
    logic [31:0] i_wr_data;

    modport slave (
        input  i_req, i_addr, i_flush, i_wr_en, i_wr_addr, i_wr_data,
        output o_gnt, o_pc_enable, o_rvalid, o_rdata, o_err
    );

    modport master (
        output i_req, i_addr, i_flush, i_wr_en, i_wr_addr, i_wr_data,
        input  o_gnt, o_pc_enable, o_rvalid, o_rdata, o_err
    );
endinterface

// File: rtl/imem_resp_array.sv
// imem_array: DEPTH_WORDS x 32 synchronous RAM, one write port, one read port.
//   i_clk, in_rst          : clock, async active-low reset (read register only)
//   i_rd_en, i_rd_idx      : read strobe and word index
//   o_rd_data              : registered read data (0 after reset)
//   i_wr_en, i_wr_idx, i_wr_data : write strobe, word index, data
// A read and write to the same word on the same edge return the old data.
module imem_array #(
    parameter int DEPTH_WORDS = 1024,
    localparam int AW = $clog2(DEPTH_WORDS)
) (
    input  logic          i_clk,
    input  logic          in_rst,
    input  logic          i_rd_en,
    input  logic [AW-1:0] i_rd_idx,
    output logic [31:0]   o_rd_data,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_idx,
    input  logic [31:0]   i_wr_data
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rd_data_q;

    // Contents are deliberately not reset.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) mem_q[i_wr_idx] <= i_wr_data;
    end

    always_ff @(posedge i_clk or negedge in_rst) begin
        if (!in_rst)      rd_data_q <= '0;
        else if (i_rd_en) rd_data_q <= mem_q[i_rd_idx];
    end

    assign o_rd_data = rd_data_q;

endmodule

// File: rtl/imem_resp.sv
// imem_resp: instruction-memory responder for the fetch stage.
//   i_clk, in_rst : clock, async active-low reset
//   bus (slave)   : fetch request/grant/response and loader write port
// One fetch outstanding at a time. A grant captures the address, waits
// WAIT_CYCLES cycles, then presents the word with a one-cycle o_rvalid.
// o_pc_enable mirrors o_gnt so the PC only advances on an accepted fetch.
module imem_resp
    import imem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        i_clk,
    input  logic        in_rst,
    imem_resp_if.slave  bus
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [2:0]  CNT_LOAD = (WAIT_CYCLES > 0) ? 3'(WAIT_CYCLES - 1) : 3'd0;
    localparam logic [31:0] DEPTH_U  = 32'(DEPTH_WORDS);

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic        err_q;
    logic        gnt;
    logic        enter_resp;
    logic        fault_d;
    logic        wr_ok;
    logic [31:0] ram_rdata;

    // Gated by reset so nothing is accepted while the block is held in reset.
    assign gnt = in_rst & bus.i_req & ~bus.i_flush & ((state_q == IDLE) | (state_q == RESP));

    // State register
    always_ff @(posedge i_clk or negedge in_rst) begin
        if (!in_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            if (enter_resp) err_q <= fault_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        case (state_q)
            IDLE, RESP: begin
                if (gnt) begin
                    addr_d  = bus.i_addr;
                    cnt_d   = CNT_LOAD;
                    state_d = (WAIT_CYCLES > 0) ? WAIT : RESP;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (bus.i_flush)      state_d = IDLE;
                else if (cnt_q == '0) state_d = RESP;
                else                  cnt_d   = cnt_q - 3'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Every transition into RESP (including RESP->RESP on a back-to-back
    // grant) is a fresh response. addr_d is the address being captured
    // this edge when WAIT_CYCLES is 0, otherwise the held one.
    assign enter_resp = (state_d == RESP);
    assign fault_d    = addr_fault(addr_d, DEPTH_U);
    assign wr_ok      = bus.i_wr_en & ({2'b00, bus.i_wr_addr[31:2]} < DEPTH_U);

    imem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
        .i_clk     (i_clk),
        .in_rst    (in_rst),
        .i_rd_en   (enter_resp & ~fault_d),
        .i_rd_idx  (addr_d[AW+1:2]),
        .o_rd_data (ram_rdata),
        .i_wr_en   (wr_ok),
        .i_wr_idx  (bus.i_wr_addr[AW+1:2]),
        .i_wr_data (bus.i_wr_data)
    );

    // Outputs
    always_comb begin
        bus.o_gnt       = gnt;
        bus.o_pc_enable = gnt;
        bus.o_rvalid    = (state_q == RESP) & ~bus.i_flush;
        bus.o_err       = err_q;
        // Both err_q and the RAM read register only change on RESP entry,
        // so the word holds until the next response.
        bus.o_rdata     = err_q ? NOP : ram_rdata;
    end

endmodule

// File: tb/tb_imem_resp.sv
// tb_imem_resp: directed bench for imem_resp. Three instances with
// WAIT_CYCLES = 1, 0 and 3 share the clock and reset; each test drives one.
module tb_imem_resp;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    imem_resp_if ba ();
    imem_resp_if bb ();
    imem_resp_if bc ();

    imem_resp #(.DEPTH_WORDS(16), .WAIT_CYCLES(1)) u_a (.i_clk(clk), .in_rst(rst_n), .bus(ba));
    imem_resp #(.DEPTH_WORDS(16), .WAIT_CYCLES(0)) u_b (.i_clk(clk), .in_rst(rst_n), .bus(bb));
    imem_resp #(.DEPTH_WORDS(16), .WAIT_CYCLES(3)) u_c (.i_clk(clk), .in_rst(rst_n), .bus(bc));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic ld(input int u, input logic [31:0] a, input logic [31:0] d);
        case (u)
            0:       begin ba.i_wr_en = 1'b1; ba.i_wr_addr = a; ba.i_wr_data = d; end
            1:       begin bb.i_wr_en = 1'b1; bb.i_wr_addr = a; bb.i_wr_data = d; end
            default: begin bc.i_wr_en = 1'b1; bc.i_wr_addr = a; bc.i_wr_data = d; end
        endcase
        nxt();
        ba.i_wr_en = 1'b0;
        bb.i_wr_en = 1'b0;
        bc.i_wr_en = 1'b0;
    endtask

    logic [31:0] bw [4];

    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

    initial begin
        bw[0] = 32'hA000_0001; bw[1] = 32'hA000_0002;
        bw[2] = 32'hA000_0003; bw[3] = 32'hA000_0004;
        rst_n = 1'b0;
        ba.i_req = 0; ba.i_addr = 0; ba.i_flush = 0; ba.i_wr_en = 0; ba.i_wr_addr = 0; ba.i_wr_data = 0;
        bb.i_req = 0; bb.i_addr = 0; bb.i_flush = 0; bb.i_wr_en = 0; bb.i_wr_addr = 0; bb.i_wr_data = 0;
        bc.i_req = 0; bc.i_addr = 0; bc.i_flush = 0; bc.i_wr_en = 0; bc.i_wr_addr = 0; bc.i_wr_data = 0;

        // Reset state, with a request pending that must not be granted
        ba.i_req = 1'b1;
        #3;
        chk("rst_gnt",    ba.o_gnt,       0);
        chk("rst_pcen",   ba.o_pc_enable, 0);
        chk("rst_rvalid", ba.o_rvalid,    0);
        chk("rst_rdata",  ba.o_rdata,     0);
        chk("rst_err",    ba.o_err,       0);
        nxt();
        rst_n = 1'b1;
        ba.i_req = 1'b0;

        ld(0, 0, 32'h0050_0093);
        for (int i = 0; i < 4; i++) ld(1, 32'(4 * i), bw[i]);
        ld(1, 32, 32'h1111_1111);
        ld(2, 4, 32'h2222_2222);
        ld(2, 0, 32'h3333_3333);

        // WAIT_CYCLES=1: grant N, wait N+1, response N+2
        ba.i_req = 1'b1; ba.i_addr = 0;
        @(negedge clk);
        chk("A_gnt",  ba.o_gnt, 1);
        chk("A_pcen", ba.o_pc_enable, 1);
        chk("A_rv0",  ba.o_rvalid, 0);
        nxt();
        @(negedge clk);
        chk("A_wait_gnt",  ba.o_gnt, 0);
        chk("A_wait_pcen", ba.o_pc_enable, 0);
        chk("A_wait_rv",   ba.o_rvalid, 0);
        nxt();
        ba.i_req = 1'b0;
        @(negedge clk);
        chk("A_rv",    ba.o_rvalid, 1);
        chk("A_rdata", ba.o_rdata, 32'h0050_0093);
        chk("A_err",   ba.o_err, 0);
        nxt();
        @(negedge clk);
        chk("A_rv_end", ba.o_rvalid, 0);

        // WAIT_CYCLES=0: back-to-back fetches
        nxt();
        bb.i_req = 1'b1; bb.i_addr = 0;
        @(negedge clk);
        chk("B_gnt0", bb.o_gnt, 1);
        chk("B_rv0",  bb.o_rvalid, 0);
        for (int i = 1; i < 4; i++) begin
            nxt();
            bb.i_addr = 32'(4 * i);
            @(negedge clk);
            chk("B_gnt",   bb.o_gnt, 1);
            chk("B_rv",    bb.o_rvalid, 1);
            chk("B_rdata", bb.o_rdata, bw[i-1]);
        end
        nxt();
        bb.i_req = 1'b0;
        @(negedge clk);
        chk("B_gnt_idle", bb.o_gnt, 0);
        chk("B_rv_last",  bb.o_rvalid, 1);
        chk("B_rdata_last", bb.o_rdata, bw[3]);
        nxt();
        @(negedge clk);
        chk("B_rv_end", bb.o_rvalid, 0);

        // Faults: misaligned, then first word past the end, then a clean fetch
        nxt();
        bb.i_req = 1'b1; bb.i_addr = 32'h2;
        nxt();
        bb.i_addr = 32'd64;
        @(negedge clk);
        chk("F_mis_rv",    bb.o_rvalid, 1);
        chk("F_mis_err",   bb.o_err, 1);
        chk("F_mis_rdata", bb.o_rdata, 32'h0000_0013);
        nxt();
        bb.i_addr = 32'd4;
        @(negedge clk);
        chk("F_oor_rv",    bb.o_rvalid, 1);
        chk("F_oor_err",   bb.o_err, 1);
        chk("F_oor_rdata", bb.o_rdata, 32'h0000_0013);
        nxt();
        bb.i_req = 1'b0;
        @(negedge clk);
        chk("F_ok_err",   bb.o_err, 0);
        chk("F_ok_rdata", bb.o_rdata, bw[1]);

        // Write and RESP-entry read of word 8 on the same edge
        nxt();
        bb.i_req = 1'b1; bb.i_addr = 32'd32;
        bb.i_wr_en = 1'b1; bb.i_wr_addr = 32'd32; bb.i_wr_data = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("W_gnt", bb.o_gnt, 1);
        nxt();
        bb.i_wr_en = 1'b0;
        @(negedge clk);
        chk("W_old", bb.o_rdata, 32'h1111_1111);
        nxt();
        bb.i_req = 1'b0;
        @(negedge clk);
        chk("W_new", bb.o_rdata, 32'hDEAD_BEEF);

        // Out-of-range write is dropped (must not alias onto word 0)
        ld(1, 32'd64, 32'hBAD0_BAD0);
        bb.i_req = 1'b1; bb.i_addr = 0;
        nxt();
        bb.i_req = 1'b0;
        @(negedge clk);
        chk("W_oor_drop", bb.o_rdata, bw[0]);

        // WAIT_CYCLES=3: flush during WAIT discards the fetch
        nxt();
        bc.i_req = 1'b1; bc.i_addr = 0;
        @(negedge clk);
        chk("C_gnt", bc.o_gnt, 1);
        nxt();
        bc.i_req = 1'b0;
        @(negedge clk);
        chk("C_rv1", bc.o_rvalid, 0);
        nxt();
        bc.i_flush = 1'b1;
        @(negedge clk);
        chk("C_rv2",   bc.o_rvalid, 0);
        chk("C_pcen2", bc.o_pc_enable, 0);
        nxt();
        bc.i_flush = 1'b0; bc.i_req = 1'b1; bc.i_addr = 32'd4;
        @(negedge clk);
        chk("C_regnt", bc.o_gnt, 1);
        chk("C_rv3",   bc.o_rvalid, 0);
        nxt();
        bc.i_req = 1'b0;
        @(negedge clk);
        chk("C_rv4", bc.o_rvalid, 0);
        for (int k = 5; k <= 6; k++) begin
            nxt();
            @(negedge clk);
            chk("C_rv56", bc.o_rvalid, 0);
        end
        nxt();
        @(negedge clk);
        chk("C_rv7",    bc.o_rvalid, 1);
        chk("C_rdata7", bc.o_rdata, 32'h2222_2222);

        // Reset asserted during WAIT
        nxt();
        bc.i_req = 1'b1; bc.i_addr = 0;
        @(negedge clk);
        chk("R_gnt", bc.o_gnt, 1);
        nxt();
        #2;
        rst_n = 1'b0;
        #1;
        chk("R_gnt_rst",   bc.o_gnt, 0);
        chk("R_pcen_rst",  bc.o_pc_enable, 0);
        chk("R_rv_rst",    bc.o_rvalid, 0);
        chk("R_rdata_rst", bc.o_rdata, 0);
        chk("R_err_rst",   bc.o_err, 0);
        bc.i_req = 1'b0;
        nxt();
        nxt();
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("R_no_stale", bc.o_rvalid, 0);
            nxt();
        end
        bc.i_req = 1'b1; bc.i_addr = 0;
        @(negedge clk);
        chk("R_first_gnt", bc.o_gnt, 1);
        nxt();
        bc.i_req = 1'b0;
        nxt();
        nxt();
        nxt();
        @(negedge clk);
        chk("R_rv",    bc.o_rvalid, 1);
        chk("R_rdata", bc.o_rdata, 32'h3333_3333);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
